// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   ST_IDLE / ST_GRANT : FSM state encodings (no grant / one owner)
//   N_REQ, IDX_W       : requester count and encoded index width
//   idx2onehot()       : binary index to one-hot grant vector
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 lowest-index priority encoder.
//   req   : request vector, bit 0 has the highest priority
//   idx   : index of the lowest set bit (0 when none set)
//   valid : high when any request bit is set
module prio_enc4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    always_comb begin
        idx   = '0;
        valid = |req;
        if (req[0])      idx = 2'd0;
        else if (req[1]) idx = 2'd1;
        else if (req[2]) idx = 2'd2;
        else if (req[3]) idx = 2'd3;
    end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded grant hold time.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req[3:0]  : level requests, bit i = requester i
//   gnt[3:0]  : registered one-hot grant, zero when idle
//   gnt_id    : binary index of the owner, 0 when idle
//   gnt_valid : any grant active
// The owner keeps the grant while requesting, for at most MAX_HOLD
// cycles when someone else is waiting; handoffs are bubble-free.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid
);
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;

    logic [N_REQ-1:0] search_req;
    logic [N_REQ-1:0] rot_req;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [IDX_W-1:0] winner;
    logic             owner_req;

    // The current owner never competes in a search: a search only happens
    // at a handoff point, where either the owner has dropped its request
    // or it has used up its hold time. In IDLE gnt_q is zero.
    assign search_req = req & ~gnt_q;

    // Rotate right by ptr so the search starts at ptr; the 2-bit index
    // sum wraps 3->0 naturally.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot_req[gi] = search_req[IDX_W'(gi) + ptr_q];
        end
    endgenerate

    prio_enc4 u_enc (
        .req   (rot_req),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign winner    = enc_idx + ptr_q;
    assign owner_req = req[gnt_id_q];

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    state_d  = ST_GRANT;
                    gnt_d    = idx2onehot(winner);
                    gnt_id_d = winner;
                    ptr_d    = winner + IDX_W'(1);
                    cnt_d    = CW'(1);
                end
            end
            default: begin
                if (owner_req && (cnt_q < CW'(MAX_HOLD))) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (enc_valid) begin
                    // Handoff: either hold time expired with contention,
                    // or the owner released while others are pending.
                    gnt_d    = idx2onehot(winner);
                    gnt_id_d = winner;
                    ptr_d    = winner + IDX_W'(1);
                    cnt_d    = CW'(1);
                end else if (owner_req) begin
                    // Hold time expired but nobody else wants it: restart
                    // the hold window without dropping the grant.
                    cnt_d = CW'(1);
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    cnt_d    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;
    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the resource, where the next search
    // starts, and how long the owner has held it.
    int m_owner = -1;
    int m_next  = 0;
    int m_held  = 0;

    // First requester at or after 'start' (wrapping), skipping 'excl'.
    function automatic int first_from(input logic [3:0] r, input int start, input int excl);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (start + k) % 4;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner < 0) begin
            w = first_from(r, m_next, -1);
            if (w >= 0) begin
                m_owner = w; m_next = (w + 1) % 4; m_held = 1;
            end
        end else if (r[m_owner] && m_held < MAXH) begin
            m_held++;
        end else begin
            w = first_from(r, m_next, m_owner);
            if (w >= 0) begin
                m_owner = w; m_next = (w + 1) % 4; m_held = 1;
            end else if (r[m_owner]) begin
                m_held = 1;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    // Cycle-by-cycle compare against the model.
    always @(posedge clk or posedge rst) begin
        logic [3:0] eg;
        logic [1:0] eid;
        if (rst) begin
            m_owner = -1; m_next = 0; m_held = 0;
        end else begin
            model_step(req);
        end
        #1;
        eg  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== (m_owner >= 0)) begin
            errors++;
            $display("FAIL model_cmp t=%0t req=%b: got gnt=%b id=%0d v=%b, expected gnt=%b id=%0d v=%b",
                     $time, req, gnt, gnt_id, gnt_valid, eg, eid, (m_owner >= 0));
        end else begin
            $display("cycle t=%0t req=%b gnt=%b id=%0d ok", $time, req, gnt, gnt_id);
        end
    end

    task automatic expect_lit(input string name, input logic [3:0] eg, input logic [1:0] eid);
        checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== (eg != 4'b0)) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d v=%b, expected gnt=%b id=%0d",
                     name, gnt, gnt_id, gnt_valid, eg, eid);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset with all requesting: grant held at zero throughout.
        req = 4'b1111;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            after_edge();
            expect_lit("reset_hold", 4'b0000, 2'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        after_edge();
        expect_lit("first_after_reset", 4'b0001, 2'd0);

        // Single requester, hold 3 cycles then drop.
        do_reset();
        req = 4'b0100;
        after_edge();
        expect_lit("single_grant", 4'b0100, 2'd2);
        after_edge();
        after_edge();
        expect_lit("single_hold", 4'b0100, 2'd2);
        @(negedge clk);
        req = 4'b0000;
        after_edge();
        expect_lit("single_release", 4'b0000, 2'd0);

        // Bubble-free handoff on release.
        do_reset();
        req = 4'b1010;
        after_edge();
        expect_lit("handoff_first", 4'b0010, 2'd1);
        @(negedge clk);
        req = 4'b1000;
        after_edge();
        expect_lit("handoff_next", 4'b1000, 2'd3);

        // Full load: each requester in turn for exactly MAXH cycles.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5 * MAXH; i++) begin
            after_edge();
            expect_lit("full_load", 4'(1 << ((i / MAXH) % 4)), 2'((i / MAXH) % 4));
        end

        // Sole requester keeps the grant past the hold limit.
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            after_edge();
            expect_lit("sole_past_timeout", 4'b0001, 2'd0);
        end

        // Asynchronous reset between edges mid-grant.
        do_reset();
        req = 4'b0100;
        after_edge();
        expect_lit("async_pre", 4'b0100, 2'd2);
        @(negedge clk);
        #1 rst = 1'b1;
        #2 expect_lit("async_drop", 4'b0000, 2'd0);
        #1 rst = 1'b0;
        req = 4'b1111;
        after_edge();
        expect_lit("async_after", 4'b0001, 2'd0);

        // Randomized traffic, checked by the model process.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            else if ($urandom_range(0, 5) == 0) req = req ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 150) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
